fp_mul_pipe: RTL and testbench
==============================

// Module: fp_mul_pipe
// PURPOSE
//  Parametrised IEEE-754-style floating-point multiplier for the systolic array PE datapath.
//  Generalises the fixed FP32 single_float format to any EXP_W/MNTSA_W.
//  3-stage pipeline with valid/ready handshake, round-to-nearest-even and per-result error flags.
//  Also keeps a sticky error register for the array controller.
// PARAMETERS
//  EXP_W    8   exponent width; bias = 2**(EXP_W-1)-1
//  MNTSA_W  23  stored mantissa width (hidden 1 omitted); FLT_W = 1+EXP_W+MNTSA_W (localparam)
// PORTS
//  clk         in   1      single clock, rising edge
//  rst         in   1      asynchronous, active-high reset
//  in_valid    in   1      operand pair valid
//  in_ready    out  1      block can accept operands this cycle
//  in_a        in   FLT_W  operand A {sign,exp,mantissa}
//  in_b        in   FLT_W  operand B
//  out_valid   out  1      result valid
//  out_ready   in   1      consumer accepts result
//  out_data    out  FLT_W  product
//  out_err     out  3      {invalid,overflow,underflow} for out_data; valid only with out_valid
//  sticky_err  out  3      OR of all out_err delivered since reset/clear
//  clr_sticky  in   1      synchronous clear of sticky_err
// BEHAVIOUR
//  Reset: all stage valids, out_valid, out_data, out_err and sticky_err = 0; in-flight ops are discarded.
//  Handshake: global advance en = !out_valid | out_ready; in_ready = en (combinational).
//   Transfer in on in_valid&in_ready; transfer out on out_valid&out_ready.
//   If !en, all stages hold and out_data/out_err stay stable.
//  Latency: exactly 3 cycles from accept to out_valid when unstalled; throughput 1/cycle.
//   Order is preserved; no drop and no duplication.
//  S1: sign = a.s^b.s; exp_sum = ea+eb-bias, signed EXP_W+2 bits; classify each operand zero/inf/nan.
//   exp==0 is flushed to zero (denormals -> signed zero, no flag).
//  S2: mantissa product of (1.ma)*(1.mb), 2*(MNTSA_W+1) bits; special-case tag passed along.
//  S3: normalise (if product MSB set: shift right 1, exp+1); RNE using guard/round/sticky.
//   A rounding carry-out renormalises and increments exp. Then pack the result and set flags:
//   - NaN input, or inf*0: out = canonical qNaN (sign 0, exp all 1s, mantissa MSB 1); invalid=1
//   - inf*finite(nonzero): out = signed inf; no flags
//   - zero*finite: out = signed zero; no flags
//   - final exp >= 2**EXP_W-1: out = signed inf; overflow=1
//   - final exp <= 0: out = signed zero (flush); underflow=1
//  Sticky: each cycle sticky <= (clr_sticky ? 0 : sticky) | (out_valid&out_ready ? out_err : 0).
//   If clr_sticky is asserted in the same cycle as a new flag, the new flag wins.
// STRUCTURE
//  dsp_sys_arr_pkg additions:
//   - typedef fp_err_t {invalid, overflow, underflow}; existing error struct unchanged.
//   - default FP32 EXP_W/MNTSA_W are reused as parameter defaults.
//   - function fp_bias(exp_w).
//  Sub-module fp_round_norm: combinational S3 normalise/round/pack/flag logic, same parameters.
//  Stage registers stay in fp_mul_pipe.
// TESTING
//  1. 0x3FC00000*0x40000000 (1.5*2) -> 0x40400000, out_valid 3 cycles after accept, out_err=0.
//  2. 0x3F800001*0x3F800001 -> 0x3F800002 (RNE); 0x3F800000*0xBF800000 -> 0xBF800000.
//  3. 0x7F000000*0x7F000000 -> 0x7F800000, overflow=1, sticky_err=3'b010.
//     Then clr_sticky -> 0. Repeat with a clear coincident with a new flag -> sticky stays set.
//  4. 0x00800000*0x00800000 -> 0x00000000, underflow=1.
//     0x00000001*0x3F800000 -> 0x00000000, flags 0 (input flush).
//  5. 0x7F800000*0x00000000 -> 0x7FC00000, invalid=1.
//     0x7FC00000*0x3F800000 -> 0x7FC00000, invalid=1.
//     0xFF800000*0x40000000 -> 0xFF800000, flags 0.
//  6. Stream 8 ops with out_ready low 4 cycles mid-stream: in_ready drops, out_data holds, all 8 results in order.
//     Assert rst with 2 ops in flight -> no out_valid after release.
//     Also check an EXP_W=5/MNTSA_W=10 instance: 0x3C00*0x4000 -> 0x4000.

Source files
------------

// File: rtl/dsp_sys_arr_pkg.sv
// Shared types and helpers for the systolic-array PE datapath.
// Holds the FP32 format defaults and the floating-point error/special-case types.
package dsp_sys_arr_pkg;

  localparam int unsigned FP32_EXP_W   = 8;
  localparam int unsigned FP32_MNTSA_W = 23;

  typedef struct packed {
    logic invalid;
    logic overflow;
    logic underflow;
  } fp_err_t;

  // Special-case tag carried down the multiplier pipe next to the operands
  typedef enum logic [1:0] {
    SPC_NONE = 2'd0,
    SPC_ZERO = 2'd1,
    SPC_INF  = 2'd2,
    SPC_NAN  = 2'd3
  } fp_spc_t;

  function automatic int unsigned fp_bias(input int unsigned exp_w);
    return (32'd1 << (exp_w - 1)) - 32'd1;
  endfunction

endpackage

// File: rtl/fp_mul_pipe_round_norm.sv
// Final multiplier stage: normalise the mantissa product, round to nearest even,
// pack the result and raise the invalid/overflow/underflow flags.
module fp_round_norm
  import dsp_sys_arr_pkg::*;
#(
  parameter int unsigned EXP_W   = FP32_EXP_W,
  parameter int unsigned MNTSA_W = FP32_MNTSA_W
) (
  input  logic                         sign,
  input  logic [EXP_W+1:0]             exp_in,
  input  logic [2*MNTSA_W+1:0]         prod,
  input  fp_spc_t                      spc,
  output logic [EXP_W+MNTSA_W:0]       res_c,
  output fp_err_t                      err_c
);

  localparam int unsigned FLT_W = 1 + EXP_W + MNTSA_W;
  localparam int unsigned ES    = EXP_W + 2;
  localparam int unsigned PW    = 2 * (MNTSA_W + 1);
  localparam int unsigned NW    = PW - 1;
  localparam int unsigned MW1   = MNTSA_W + 1;
  localparam logic [ES-1:0]    EXP_MAX = ES'((32'd1 << EXP_W) - 32'd1);
  localparam logic [FLT_W-1:0] QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MNTSA_W-1){1'b0}}};

  logic [NW-1:0]      norm;
  logic [ES-1:0]      exp_n;
  logic [ES-1:0]      exp_f;
  logic [MNTSA_W-1:0] mant;
  logic               guard;
  logic               rnd;
  logic               sticky;
  logic               rnd_up;
  logic [MNTSA_W:0]   mant_r;
  logic               ovf;
  logic               unf;

  always_comb begin
    // Product lies in [1,4); drop the hidden one and align so the fraction starts at the top
    norm   = prod[PW-1] ? prod[NW-1:0] : {prod[NW-2:0], 1'b0};
    exp_n  = exp_in + ES'(prod[PW-1]);
    mant   = norm[NW-1 -: MNTSA_W];
    guard  = norm[MNTSA_W];
    rnd    = norm[MNTSA_W-1];
    sticky = |norm[MNTSA_W-2:0];
    rnd_up = guard && (rnd || sticky || mant[0]);
    mant_r = {1'b0, mant} + MW1'(rnd_up);
    // A carry out of the mantissa leaves an all-zero fraction, so only the exponent moves
    exp_f  = exp_n + ES'(mant_r[MNTSA_W]);
    ovf    = !exp_f[ES-1] && (exp_f >= EXP_MAX);
    unf    = exp_f[ES-1] || (exp_f == '0);

    res_c  = {sign, exp_f[EXP_W-1:0], mant_r[MNTSA_W-1:0]};
    err_c  = '0;
    case (spc)
      SPC_NAN: begin
        res_c         = QNAN;
        err_c.invalid = 1'b1;
      end
      SPC_INF:  res_c = {sign, {EXP_W{1'b1}}, {MNTSA_W{1'b0}}};
      SPC_ZERO: res_c = {sign, {(FLT_W-1){1'b0}}};
      default: begin
        if (ovf) begin
          res_c          = {sign, {EXP_W{1'b1}}, {MNTSA_W{1'b0}}};
          err_c.overflow = 1'b1;
        end else if (unf) begin
          res_c           = {sign, {(FLT_W-1){1'b0}}};
          err_c.underflow = 1'b1;
        end
      end
    endcase
  end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage parametrised floating-point multiplier with valid/ready handshake,
// per-result error flags and a sticky error register for the array controller.
module fp_mul_pipe
  import dsp_sys_arr_pkg::*;
#(
  parameter int unsigned EXP_W   = FP32_EXP_W,
  parameter int unsigned MNTSA_W = FP32_MNTSA_W,
  localparam int unsigned FLT_W  = 1 + EXP_W + MNTSA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [FLT_W-1:0] in_a,
  input  logic [FLT_W-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [FLT_W-1:0] out_data,
  output logic [2:0]       out_err,
  output logic [2:0]       sticky_err,
  input  logic             clr_sticky
);

  localparam int unsigned ES = EXP_W + 2;
  localparam int unsigned PW = 2 * (MNTSA_W + 1);
  localparam logic [ES-1:0] BIAS = ES'(fp_bias(EXP_W));

  logic en;

  logic [EXP_W-1:0]   ea;
  logic [EXP_W-1:0]   eb;
  logic [MNTSA_W-1:0] ma;
  logic [MNTSA_W-1:0] mb;
  logic               a_zero, a_inf, a_nan;
  logic               b_zero, b_inf, b_nan;
  logic [ES-1:0]      exp_sum_c;
  fp_spc_t            spc_c;

  logic               s1_valid;
  logic               s1_sign;
  logic [ES-1:0]      s1_exp;
  fp_spc_t            s1_spc;
  logic [MNTSA_W-1:0] s1_ma;
  logic [MNTSA_W-1:0] s1_mb;

  logic               s2_valid;
  logic               s2_sign;
  logic [ES-1:0]      s2_exp;
  fp_spc_t            s2_spc;
  logic [PW-1:0]      s2_prod;

  logic [FLT_W-1:0]   res_c;
  fp_err_t            err_c;

  // Whole pipe advances together whenever the output slot is free or being drained
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // S1: operand classification and biased exponent sum
  always_comb begin
    ea     = in_a[FLT_W-2 -: EXP_W];
    eb     = in_b[FLT_W-2 -: EXP_W];
    ma     = in_a[MNTSA_W-1:0];
    mb     = in_b[MNTSA_W-1:0];
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    a_inf  = (ea == '1) && (ma == '0);
    b_inf  = (eb == '1) && (mb == '0);
    a_nan  = (ea == '1) && (ma != '0);
    b_nan  = (eb == '1) && (mb != '0);
    exp_sum_c = ES'(ea) + ES'(eb) - BIAS;
    spc_c  = SPC_NONE;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      spc_c = SPC_NAN;
    end else if (a_inf || b_inf) begin
      spc_c = SPC_INF;
    end else if (a_zero || b_zero) begin
      spc_c = SPC_ZERO;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_exp   <= '0;
      s1_spc   <= SPC_NONE;
      s1_ma    <= '0;
      s1_mb    <= '0;
      s2_valid <= 1'b0;
      s2_sign  <= 1'b0;
      s2_exp   <= '0;
      s2_spc   <= SPC_NONE;
      s2_prod  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= '0;
    end else if (en) begin
      s1_valid <= in_valid;
      s1_sign  <= in_a[FLT_W-1] ^ in_b[FLT_W-1];
      s1_exp   <= exp_sum_c;
      s1_spc   <= spc_c;
      s1_ma    <= ma;
      s1_mb    <= mb;

      // S2: full-width product of the significands with hidden ones restored
      s2_valid <= s1_valid;
      s2_sign  <= s1_sign;
      s2_exp   <= s1_exp;
      s2_spc   <= s1_spc;
      s2_prod  <= PW'({1'b1, s1_ma}) * PW'({1'b1, s1_mb});

      out_valid <= s2_valid;
      if (s2_valid) begin
        out_data <= res_c;
        out_err  <= err_c;
      end
    end
  end

  fp_round_norm #(
    .EXP_W   (EXP_W),
    .MNTSA_W (MNTSA_W)
  ) u_round_norm (
    .sign   (s2_sign),
    .exp_in (s2_exp),
    .prod   (s2_prod),
    .spc    (s2_spc),
    .res_c  (res_c),
    .err_c  (err_c)
  );

  // A flag delivered in the same cycle as a clear survives the clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_err <= '0;
    end else begin
      sticky_err <= (clr_sticky ? 3'b000 : sticky_err) | ((out_valid && out_ready) ? out_err : 3'b000);
    end
  end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Bench for fp_mul_pipe: directed corner cases plus randomized traffic scored against
// a real-arithmetic reference model, with an FP16-shaped instance for parametrisation.
module tb_fp_mul_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [2:0]  out_err;
  logic [2:0]  sticky_err;
  logic        clr_sticky;

  logic        h_in_valid;
  logic        h_in_ready;
  logic [15:0] h_in_a;
  logic [15:0] h_in_b;
  logic        h_out_valid;
  logic        h_out_ready;
  logic [15:0] h_out_data;
  logic [2:0]  h_out_err;
  logic [2:0]  h_sticky;
  logic        h_clr;

  int checks = 0;
  int errors = 0;
  int cycle_n = 0;
  int last_lat = 0;
  logic        hold_pend = 1'b0;
  logic [2:0]  sticky_m = 3'b000;
  logic [34:0] exp_q[$];
  int          cyc_q[$];

  always #5 clk = ~clk;

  fp_mul_pipe dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_err    (out_err),
    .sticky_err (sticky_err),
    .clr_sticky (clr_sticky)
  );

  fp_mul_pipe #(.EXP_W(5), .MNTSA_W(10)) dut_h (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (h_in_valid),
    .in_ready   (h_in_ready),
    .in_a       (h_in_a),
    .in_b       (h_in_b),
    .out_valid  (h_out_valid),
    .out_ready  (h_out_ready),
    .out_data   (h_out_data),
    .out_err    (h_out_err),
    .sticky_err (h_sticky),
    .clr_sticky (h_clr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: exact product in double precision, then RNE to FP32 and range rules
  function automatic logic [34:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic [7:0]  ea, eb;
    logic [22:0] ma, mb, m;
    logic [23:0] mm;
    logic        s, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, up;
    real         ra, rb, p;
    logic [63:0] bits;
    int          e;
    ea = a[30:23]; eb = b[30:23]; ma = a[22:0]; mb = b[22:0];
    s = a[31] ^ b[31];
    a_nan = (ea == 8'hFF) && (ma != 0); b_nan = (eb == 8'hFF) && (mb != 0);
    a_inf = (ea == 8'hFF) && (ma == 0); b_inf = (eb == 8'hFF) && (mb == 0);
    a_zero = (ea == 0); b_zero = (eb == 0);
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) return {3'b100, 32'h7FC00000};
    if (a_inf || b_inf) return {3'b000, s, 8'hFF, 23'h0};
    if (a_zero || b_zero) return {3'b000, s, 31'h0};
    ra = $bitstoreal({1'b0, 11'(int'(ea) + 896), ma, 29'b0});
    rb = $bitstoreal({1'b0, 11'(int'(eb) + 896), mb, 29'b0});
    p = ra * rb;
    bits = $realtobits(p);
    e = int'(bits[62:52]) - 896;
    m = bits[51:29];
    up = bits[28] && ((|bits[27:0]) || m[0]);
    mm = {1'b0, m} + 24'(up);
    if (mm[23]) e++;
    m = mm[22:0];
    if (e >= 255) return {3'b010, s, 8'hFF, 23'h0};
    if (e <= 0) return {3'b001, s, 31'h0};
    return {3'b000, s, 8'(e), m};
  endfunction

  function automatic logic [31:0] rnd_fp();
    int unsigned r;
    logic [7:0]  e;
    logic [22:0] m;
    r = $urandom_range(0, 9);
    m = 23'($urandom);
    if (r == 0) begin
      e = 8'hFF;
      if ($urandom_range(0, 1) == 0) m = '0;
    end else if (r == 1) e = 8'h00;
    else if (r < 4) e = 8'($urandom_range(0, 255));
    else e = 8'($urandom_range(64, 190));
    return {1'($urandom_range(0, 1)), e, m};
  endfunction

  // One clock cycle: drive at the falling edge, check and score just after it
  task automatic cyc(input logic iv, input logic [31:0] a, input logic [31:0] b,
                     input logic ordy, input logic clr, input logic use_dir,
                     input logic [34:0] dexp, output logic acc);
    logic [34:0] e;
    logic [2:0]  xerr;
    @(negedge clk);
    in_valid = iv; in_a = a; in_b = b; out_ready = ordy; clr_sticky = clr;
    #1;
    cycle_n++;
    xerr = 3'b000;
    chk("sticky", 64'(sticky_err), 64'(sticky_m));
    chk("in_ready", 64'(in_ready), 64'(!out_valid || ordy));
    if (hold_pend) chk("hold_valid", 64'(out_valid), 64'(1'b1));
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_valid", 64'(out_valid), 64'(1'b0));
      end else if (ordy) begin
        e = exp_q.pop_front();
        last_lat = cycle_n - cyc_q.pop_front();
        chk("data", 64'(out_data), 64'(e[31:0]));
        chk("err", 64'(out_err), 64'(e[34:32]));
        xerr = e[34:32];
      end else begin
        chk("stall_data", 64'(out_data), 64'(exp_q[0][31:0]));
      end
    end
    hold_pend = out_valid && !ordy;
    sticky_m = (clr ? 3'b000 : sticky_m) | xerr;
    acc = iv && in_ready;
    if (acc) begin
      exp_q.push_back(use_dir ? dexp : ref_mul(a, b));
      cyc_q.push_back(cycle_n);
    end
  endtask

  task automatic idle(input logic ordy, input logic clr);
    logic acc;
    cyc(1'b0, 32'h0, 32'h0, ordy, clr, 1'b0, 35'h0, acc);
  endtask

  task automatic dop(input logic [31:0] a, input logic [31:0] b, input logic [34:0] e);
    logic acc;
    cyc(1'b1, a, b, 1'b1, 1'b0, 1'b1, e, acc);
    chk("accept", 64'(acc), 64'(1'b1));
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) idle(1'b1, 1'b0);
    chk("drain", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic h_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] ed, input logic [2:0] ee);
    int k;
    @(negedge clk);
    h_in_valid = 1'b1; h_in_a = a; h_in_b = b;
    #1;
    chk({tag, "_rdy"}, 64'(h_in_ready), 64'(1'b1));
    @(negedge clk);
    h_in_valid = 1'b0;
    k = 0;
    while (!h_out_valid && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_lat"}, 64'(k), 64'(2));
    chk({tag, "_valid"}, 64'(h_out_valid), 64'(1'b1));
    chk({tag, "_data"}, 64'(h_out_data), 64'(ed));
    chk({tag, "_err"}, 64'(h_out_err), 64'(ee));
  endtask

  initial begin
    logic        acc;
    logic [31:0] sa[8];
    logic [31:0] sb[8];
    int          idx;

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1; clr_sticky = 1'b0;
    h_in_valid = 1'b0; h_in_a = '0; h_in_b = '0; h_out_ready = 1'b1; h_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(1'b0));
    chk("rst_out_data", 64'(out_data), 64'(0));
    chk("rst_out_err", 64'(out_err), 64'(0));
    chk("rst_sticky", 64'(sticky_err), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    // Basic product and latency
    dop(32'h3FC00000, 32'h40000000, {3'b000, 32'h40400000});
    drain();
    chk("latency", 64'(last_lat), 64'(3));

    // Rounding and sign
    dop(32'h3F800001, 32'h3F800001, {3'b000, 32'h3F800002});
    dop(32'h3F800000, 32'hBF800000, {3'b000, 32'hBF800000});
    drain();

    // Overflow, sticky set, clear, then clear racing a new flag
    dop(32'h7F000000, 32'h7F000000, {3'b010, 32'h7F800000});
    drain();
    idle(1'b1, 1'b0);
    chk("sticky_ovf", 64'(sticky_err), 64'(3'b010));
    idle(1'b1, 1'b1);
    idle(1'b1, 1'b0);
    chk("sticky_clr", 64'(sticky_err), 64'(3'b000));
    dop(32'h7F000000, 32'h7F000000, {3'b010, 32'h7F800000});
    for (int k = 0; k < 10 && !out_valid; k++) idle(1'b0, 1'b0);
    chk("ovf2_wait", 64'(out_valid), 64'(1'b1));
    idle(1'b1, 1'b1);
    idle(1'b1, 1'b0);
    chk("sticky_race", 64'(sticky_err), 64'(3'b010));
    idle(1'b1, 1'b1);

    // Underflow and input flush
    dop(32'h00800000, 32'h00800000, {3'b001, 32'h00000000});
    dop(32'h00000001, 32'h3F800000, {3'b000, 32'h00000000});
    // Specials
    dop(32'h7F800000, 32'h00000000, {3'b100, 32'h7FC00000});
    dop(32'h7FC00000, 32'h3F800000, {3'b100, 32'h7FC00000});
    dop(32'hFF800000, 32'h40000000, {3'b000, 32'hFF800000});
    drain();
    idle(1'b1, 1'b1);

    // Eight-op stream with a four-cycle output stall in the middle
    for (int i = 0; i < 8; i++) begin
      sa[i] = rnd_fp();
      sb[i] = rnd_fp();
    end
    idx = 0;
    for (int t = 0; t < 40 && idx < 8; t++) begin
      cyc(1'b1, sa[idx], sb[idx], !(t >= 3 && t < 7), 1'b0, 1'b0, 35'h0, acc);
      if (acc) idx++;
    end
    chk("stream_sent", 64'(idx), 64'(8));
    drain();

    // Randomized traffic with random backpressure and occasional clears
    for (int t = 0; t < 400; t++) begin
      cyc($urandom_range(0, 3) != 0, rnd_fp(), rnd_fp(), $urandom_range(0, 9) < 7,
          $urandom_range(0, 19) == 0, 1'b0, 35'h0, acc);
    end
    drain();

    // Reset with two operations in flight discards them
    cyc(1'b1, 32'h3F800000, 32'h40000000, 1'b1, 1'b0, 1'b0, 35'h0, acc);
    cyc(1'b1, 32'h40000000, 32'h40000000, 1'b1, 1'b0, 1'b0, 35'h0, acc);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    #1;
    chk("rst_flight_valid", 64'(out_valid), 64'(1'b0));
    chk("rst_flight_sticky", 64'(sticky_err), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    cyc_q.delete();
    sticky_m = 3'b000;
    hold_pend = 1'b0;
    for (int k = 0; k < 6; k++) begin
      idle(1'b1, 1'b0);
      chk("post_rst_valid", 64'(out_valid), 64'(1'b0));
    end

    // Half-precision instance
    h_op("h_basic", 16'h3C00, 16'h4000, 16'h4000, 3'b000);
    h_op("h_rne", 16'h3C01, 16'h3C01, 16'h3C02, 3'b000);
    h_op("h_ovf", 16'h7BFF, 16'h7BFF, 16'h7C00, 3'b010);
    @(negedge clk);
    chk("h_sticky", 64'(h_sticky), 64'(3'b010));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
